// File: rtl/fm_matrix_sequencer_if.sv
// Host, status and register-file signal bundle for fm_matrix_sequencer.
// master = the sequencer, slave = the host/register-file environment.
interface fm_matrix_sequencer_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          host_wr_valid;
  logic          host_wr_ready;
  logic [AW-1:0] host_wr_addr;
  logic [DW-1:0] host_wr_data;
  logic          rf_wren;
  logic          rf_rden;
  logic [AW-1:0] rf_w_addr;
  logic [DW-1:0] rf_w_data;
  logic [AW-1:0] rf_r_addr0;
  logic [AW-1:0] rf_r_addr1;
  logic [DW-1:0] rf_r_data0;
  logic [DW-1:0] rf_r_data1;
  logic [15:0]   sat_count;
  logic [2:0]    dbg_state;

  // Host write transfers on every cycle with host_wr_valid && host_wr_ready;
  // ready never depends on valid, and valid/addr/data hold until the transfer.
  modport master (
    input  start, abort, host_wr_valid, host_wr_addr, host_wr_data,
           rf_r_data0, rf_r_data1,
    output busy, done, host_wr_ready, rf_wren, rf_rden, rf_w_addr, rf_w_data,
           rf_r_addr0, rf_r_addr1, sat_count, dbg_state
  );

  modport slave (
    output start, abort, host_wr_valid, host_wr_addr, host_wr_data,
           rf_r_data0, rf_r_data1,
    input  busy, done, host_wr_ready, rf_wren, rf_rden, rf_w_addr, rf_w_data,
           rf_r_addr0, rf_r_addr1, sat_count, dbg_state
  );
endinterface

// File: rtl/fm_matrix_sequencer.sv
// FM modulation-matrix sweep controller: per operator, MACs NOPS level*output pairs and writes a saturated sum.
// Optional saturated-write counter enabled by FMSEQ_SAT_CNT_EN.
module fm_matrix_sequencer #(
  parameter int            DW       = 16,
  parameter int            AW       = 12,
  parameter int            NOPS     = 4,
  parameter logic [AW-1:0] MOD_BASE = 12'h000,
  parameter logic [AW-1:0] OUT_BASE = 12'h100,
  parameter logic [AW-1:0] ACC_BASE = 12'h200
) (
  input  logic                  clk,
  input  logic                  reset,
  fm_matrix_sequencer_if.master bus
);

  localparam int OpW  = $clog2(NOPS);
  localparam int AccW = 2 * DW + OpW;
  localparam logic [OpW-1:0] LAST = OpW'(NOPS - 1);
  localparam logic signed [AccW-1:0] SAT_MAX = {{(AccW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AccW-1:0] SAT_MIN = {{(AccW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                 state_q;
  logic [OpW-1:0]         op_q;
  logic [OpW-1:0]         src_q;
  logic signed [AccW-1:0] acc_q;
  logic                   rden_q;
  logic                   wr_q;
  logic                   busy_q;
  logic                   done_q;
  logic [AW-1:0]          r_addr0_q;
  logic [AW-1:0]          r_addr1_q;
  logic [AW-1:0]          w_addr_q;
  logic [DW-1:0]          w_data_q;

  logic signed [2*DW-1:0] prod;
  logic signed [AccW-1:0] acc_sum;
  logic signed [AccW-1:0] shifted;
  logic                   clip_hi;
  logic                   clip_lo;
  logic [DW-1:0]          sat_val;
  logic                   host_ready;
  logic                   host_acc;

  // NOPS is a power of two, so op*NOPS + src is just {op, src}.
  function automatic logic [AW-1:0] mod_addr(input logic [OpW-1:0] o, input logic [OpW-1:0] s);
    return MOD_BASE + AW'({o, s});
  endfunction

  function automatic logic [AW-1:0] out_addr(input logic [OpW-1:0] s);
    return OUT_BASE + AW'(s);
  endfunction

  assign prod    = $signed(bus.rf_r_data0) * $signed(bus.rf_r_data1);
  assign acc_sum = acc_q + {{OpW{prod[2*DW-1]}}, prod};
  assign shifted = acc_sum >>> (DW - 1);
  assign clip_hi = shifted > SAT_MAX;
  assign clip_lo = shifted < SAT_MIN;
  assign sat_val = clip_hi ? {1'b0, {(DW-1){1'b1}}} :
                   clip_lo ? {1'b1, {(DW-1){1'b0}}} : shifted[DW-1:0];

  // start outranks a same-cycle host write; reset holds ready low.
  assign host_ready = !reset && (state_q == S_IDLE) && !bus.start;
  assign host_acc   = bus.host_wr_valid && host_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      src_q     <= '0;
      acc_q     <= '0;
      rden_q    <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      r_addr0_q <= '0;
      r_addr1_q <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      if (bus.abort && busy_q) begin
        state_q <= S_IDLE;
        op_q    <= '0;
        src_q   <= '0;
        acc_q   <= '0;
        rden_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              state_q   <= S_READ;
              op_q      <= '0;
              src_q     <= '0;
              acc_q     <= '0;
              rden_q    <= 1'b1;
              busy_q    <= 1'b1;
              r_addr0_q <= mod_addr('0, '0);
              r_addr1_q <= out_addr('0);
            end
          end
          S_READ: begin
            // Data for src-1 arrives while src is being addressed.
            if (src_q != '0) acc_q <= acc_sum;
            if (src_q == LAST) begin
              state_q <= S_DRAIN;
              rden_q  <= 1'b0;
            end else begin
              src_q     <= src_q + 1'b1;
              r_addr0_q <= mod_addr(op_q, src_q + 1'b1);
              r_addr1_q <= out_addr(src_q + 1'b1);
            end
          end
          S_DRAIN: begin
            acc_q    <= acc_sum;
            state_q  <= S_WRITE;
            wr_q     <= 1'b1;
            w_addr_q <= ACC_BASE + AW'(op_q);
            w_data_q <= sat_val;
          end
          S_WRITE: begin
            acc_q <= '0;
            if (op_q == LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_READ;
              op_q      <= op_q + 1'b1;
              src_q     <= '0;
              rden_q    <= 1'b1;
              r_addr0_q <= mod_addr(op_q + 1'b1, '0);
              r_addr1_q <= out_addr('0);
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FMSEQ_SAT_CNT_EN
  logic        clip_q;
  logic [15:0] sat_cnt_q;

  // clip_q captures the DRAIN-cycle clip decision that the WRITE cycle commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_q    <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      clip_q <= clip_hi || clip_lo;
      if (wr_q && clip_q && (sat_cnt_q != 16'hFFFF)) sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign bus.sat_count = sat_cnt_q;
`else
  assign bus.sat_count = '0;
`endif

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.host_wr_ready = host_ready;
  assign bus.rf_wren       = wr_q || host_acc;
  assign bus.rf_w_addr     = host_acc ? bus.host_wr_addr : w_addr_q;
  assign bus.rf_w_data     = host_acc ? bus.host_wr_data : w_data_q;
  assign bus.rf_rden       = rden_q;
  assign bus.rf_r_addr0    = r_addr0_q;
  assign bus.rf_r_addr1    = r_addr1_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_fm_matrix_sequencer.sv
// Randomised scoreboard bench for fm_matrix_sequencer with a behavioural register file and MAC model.
module tb_fm_matrix_sequencer;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int NOPS = 4;
  localparam logic [AW-1:0] MOD_BASE = 12'h000;
  localparam logic [AW-1:0] OUT_BASE = 12'h100;
  localparam logic [AW-1:0] ACC_BASE = 12'h200;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fm_matrix_sequencer_if #(.DW(DW), .AW(AW)) bus ();

  fm_matrix_sequencer #(
    .DW(DW), .AW(AW), .NOPS(NOPS),
    .MOD_BASE(MOD_BASE), .OUT_BASE(OUT_BASE), .ACC_BASE(ACC_BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sat_exp = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0] mod_lv [NOPS*NOPS];
  logic [DW-1:0] out_lv [NOPS];
  logic [DW-1:0] rf_mem [1<<AW];

  // Behavioural register file: one-cycle read latency on both ports.
  always @(posedge clk) begin
    if (bus.rf_rden) begin
      bus.rf_r_data0 <= rf_mem[bus.rf_r_addr0];
      bus.rf_r_data1 <= rf_mem[bus.rf_r_addr1];
    end
    if (bus.rf_wren) rf_mem[bus.rf_w_addr] <= bus.rf_w_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every register-file write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && bus.rf_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h:%0h expected none", bus.rf_w_addr, bus.rf_w_data);
      end else begin
        check("rf_write", {bus.rf_w_addr, bus.rf_w_data}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [DW-1:0] ref_sum(input int op, output bit clipped);
    longint s = 0;
    logic [DW-1:0] r;
    for (int src = 0; src < NOPS; src++)
      s += longint'($signed(mod_lv[op*NOPS+src])) * longint'($signed(out_lv[src]));
    s = s >>> (DW - 1);
    clipped = 1'b1;
    if (s > 32767) r = 16'h7FFF;
    else if (s < -32768) r = 16'h8000;
    else begin
      r = s[DW-1:0];
      clipped = 1'b0;
    end
    return r;
  endfunction

  task automatic push_sweep(input int n_ops);
    bit c;
    logic [DW-1:0] v;
    for (int op = 0; op < n_ops; op++) begin
      v = ref_sum(op, c);
      exp_q.push_back({ACC_BASE + AW'(op), v});
      if (c) sat_exp++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a < AW'(NOPS*NOPS)) mod_lv[a] = d;
    else if (a >= OUT_BASE && a < OUT_BASE + AW'(NOPS)) out_lv[a - OUT_BASE] = d;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t;
    step();
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr  = a;
    bus.host_wr_data  = d;
    exp_q.push_back({a, d});
    model_write(a, d);
    #1;
    t = 0;
    while (!bus.host_wr_ready && t < 100) begin
      step();
      t++;
    end
    check("host_wr_accept", bus.host_wr_ready, 1'b1);
    step();
    bus.host_wr_valid = 1'b0;
  endtask

  task automatic fill(input int mode, input logic [DW-1:0] m, input logic [DW-1:0] o);
    for (int i = 0; i < NOPS*NOPS; i++)
      host_write(MOD_BASE + AW'(i), (mode == 0) ? m : DW'($urandom_range(0, 65535)));
    for (int i = 0; i < NOPS; i++)
      host_write(OUT_BASE + AW'(i), (mode == 0) ? o : DW'($urandom_range(0, 65535)));
  endtask

  task automatic check_sat();
`ifdef FMSEQ_SAT_CNT_EN
    check("sat_count", bus.sat_count, 64'(sat_exp));
`else
    check("sat_count", bus.sat_count, 0);
`endif
  endtask

  // Sweep with cycle accounting relative to the start edge; abort_at=0 means no abort.
  task automatic run_sweep(input int abort_at);
    int busy_n = 0;
    int done_at = -1;
    int wr_cyc[$];
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done && done_at < 0) done_at = k;
      if (bus.rf_wren) wr_cyc.push_back(k);
      if (k >= 7 && k <= 10) begin
        check("op1_rden", bus.rf_rden, 1'b1);
        check("op1_raddr0", bus.rf_r_addr0, 64'(MOD_BASE + AW'(NOPS + k - 7)));
        check("op1_raddr1", bus.rf_r_addr1, 64'(OUT_BASE + AW'(k - 7)));
      end
      if (abort_at != 0 && k == abort_at + 1) check("abort_idle_state", bus.dbg_state, 0);
      bus.abort = (k == abort_at);
    end
    if (abort_at == 0) begin
      check("busy_cycles", busy_n, 24);
      check("done_cycle", done_at, 25);
      check("write_count", wr_cyc.size(), 4);
      for (int i = 0; i < wr_cyc.size(); i++) check("write_cycle", wr_cyc[i], 6 * (i + 1));
    end else begin
      check("abort_busy_cycles", busy_n, abort_at);
      check("abort_no_done", done_at, -1);
      check("abort_write_count", wr_cyc.size(), 2);
    end
    check_sat();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_k;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.host_wr_valid = 1'b0;
    bus.host_wr_addr = '0;
    bus.host_wr_data = '0;
    for (int i = 0; i < (1<<AW); i++) rf_mem[i] = '0;
    for (int i = 0; i < NOPS*NOPS; i++) mod_lv[i] = '0;
    for (int i = 0; i < NOPS; i++) out_lv[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wren", bus.rf_wren, 0);
    check("rst_rden", bus.rf_rden, 0);
    check("rst_ready", bus.host_wr_ready, 0);
    check("rst_raddr0", bus.rf_r_addr0, 0);
    check("rst_sat", bus.sat_count, 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", bus.host_wr_ready, 1);

    // Same-cycle host pass-through.
    step();
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr = 12'h005;
    bus.host_wr_data = 16'h1234;
    exp_q.push_back({12'h005, 16'h1234});
    model_write(12'h005, 16'h1234);
    #1;
    check("host_wren", bus.rf_wren, 1);
    check("host_waddr", bus.rf_w_addr, 12'h005);
    check("host_wdata", bus.rf_w_data, 16'h1234);
    check("host_ready", bus.host_wr_ready, 1);
    step();
    bus.host_wr_valid = 1'b0;

    fill(0, 16'h4000, 16'h2000);
    push_sweep(NOPS);
    run_sweep(0);

    fill(0, 16'h7FFF, 16'h7FFF);
    push_sweep(NOPS);
    run_sweep(0);

    fill(0, 16'h8000, 16'h7FFF);
    push_sweep(NOPS);
    run_sweep(0);

    for (int r = 0; r < 3; r++) begin
      fill(1, '0, '0);
      push_sweep(NOPS);
      run_sweep(0);
    end

    // Abort during the DRAIN cycle (WRITE-1) of op 2.
    fill(1, '0, '0);
    push_sweep(2);
    run_sweep(17);

    // start and host write in the same cycle: sweep first, host write after DONE.
    fill(1, '0, '0);
    step();
    bus.start = 1'b1;
    bus.host_wr_valid = 1'b1;
    bus.host_wr_addr = OUT_BASE + 12'd3;
    bus.host_wr_data = 16'(($urandom_range(0, 65535)));
    push_sweep(NOPS);
    exp_q.push_back({bus.host_wr_addr, bus.host_wr_data});
    model_write(bus.host_wr_addr, bus.host_wr_data);
    #1;
    check("collide_ready", bus.host_wr_ready, 0);
    check("collide_wren", bus.rf_wren, 0);
    step();
    bus.start = 1'b0;
    acc_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.host_wr_ready) begin
        acc_k = k;
        break;
      end
    end
    check("collide_accept_cycle", acc_k, 26);
    step();
    bus.host_wr_valid = 1'b0;
    check_sat();

    // Reset asserted mid-READ clears everything at once.
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    reset = 1'b1;
    sat_exp = 0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_rden", bus.rf_rden, 0);
    check("midrst_wren", bus.rf_wren, 0);
    check("midrst_raddr0", bus.rf_r_addr0, 0);
    check("midrst_raddr1", bus.rf_r_addr1, 0);
    check("midrst_ready", bus.host_wr_ready, 0);
    check("midrst_state", bus.dbg_state, 0);
    check("midrst_sat", bus.sat_count, 0);
    step();
    reset = 1'b0;
    #1;
    check("midrst_ready_after", bus.host_wr_ready, 1);

    repeat (3) step();
    check("exp_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fm_matrix_sequencer.md
Name: fm_matrix_sequencer

Overview:
- Controller for the dual-read operand register file in the FM modulation matrix.
- On a start pulse it sweeps every operator. Per operator it reads the NOPS modulation levels and source-operator outputs in pairs (read ports 0 and 1), multiply-accumulates them, and writes one saturated modulation sum back through the write port.
- While idle it passes host configuration writes through to the same write port.
- Sits between the host/config bus and the register file.

Parameters:
- DW, 16: data width, signed Q1.(DW-1).
- AW, 12: register file address width.
- NOPS, 4: operator count; power of 2, 2..16.
- MOD_BASE, 12'h000: base of the NOPS*NOPS modulation-level region.
- OUT_BASE, 12'h100: base of the NOPS operator-output region.
- ACC_BASE, 12'h200: base of the NOPS modulation-sum region. Must not overlap the other two regions.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle sweep request.
- abort, in, 1: synchronous sweep cancel.
- busy, out, 1: sweep in progress.
- done, out, 1: one-cycle pulse when a sweep completes.
- host_wr_valid, in, 1: host write request.
- host_wr_ready, out, 1: host write accepted this cycle.
- host_wr_addr, in, AW: host write address.
- host_wr_data, in, DW: host write data.
- rf_wren, out, 1: register file write enable.
- rf_rden, out, 1: register file read enable.
- rf_w_addr, out, AW: write address.
- rf_w_data, out, DW: write data.
- rf_r_addr0, out, AW: read port 0 address (modulation level).
- rf_r_addr1, out, AW: read port 1 address (source output).
- rf_r_data0, in, DW: read port 0 data, valid 1 cycle after rden.
- rf_r_data1, in, DW: read port 1 data, valid 1 cycle after rden.
- sat_count, out, 16: saturated-write counter (optional feature).

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; op, src and accumulator clear.
  - All outputs 0, except host_wr_ready = 1 once reset deasserts.
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - host_wr_ready = !start.
  - When host_wr_valid && host_wr_ready: rf_wren = 1 in the same cycle (combinational), with rf_w_addr = host_wr_addr and rf_w_data = host_wr_data.
  - start = 1 leads to READ with op = 0, src = 0, acc = 0. start outranks a simultaneous host write; that write is not accepted.
- READ (NOPS cycles):
  - rf_rden = 1, rf_r_addr0 = MOD_BASE + op*NOPS + src, rf_r_addr1 = OUT_BASE + src.
  - src increments each cycle; after src = NOPS-1, go to DRAIN.
- Accumulation:
  - In each cycle after a read (READ with src > 0, and DRAIN): acc += signed(rf_r_data0) * signed(rf_r_data1).
  - acc width is 2*DW + log2(NOPS) bits, so it never overflows.
- DRAIN (1 cycle): absorbs the last read, then go to WRITE.
- WRITE (1 cycle):
  - rf_wren = 1, rf_w_addr = ACC_BASE + op.
  - rf_w_data = acc arithmetically shifted right by DW-1, saturated to [-2^(DW-1), 2^(DW-1)-1].
  - acc clears. If op = NOPS-1 go to DONE; otherwise op++, src = 0, go to READ.
- DONE (1 cycle): done = 1, busy = 0, then IDLE.
- busy = 1 in READ, DRAIN and WRITE.
- Latency: NOPS*(NOPS+2) busy cycles. NOPS = 4 gives 24 busy cycles; done is asserted 25 cycles after the start edge.
- Handshakes during a sweep:
  - host_wr_ready = 0 in every state except IDLE.
  - start is ignored outside IDLE.
- abort (any busy state): next state is IDLE; no write of the current op; no done; acc clears. Sums already written remain.
- Reset mid-sweep behaves like abort, asynchronously.
- rf_rden = 0 and address outputs hold their last value outside READ.

Optional Feature:
- Macro FMSEQ_SAT_CNT_EN.
- Defined:
  - sat_count increments on each WRITE-state write where saturation clipped the value.
  - Saturates at 16'hFFFF; cleared by reset only.
- Undefined: sat_count tied to 0, no counter logic.

Test Plan:
- Host write 0x1234 to 0x005 in IDLE -> rf_wren = 1 in the same cycle with addr 0x005 and data 0x1234, host_wr_ready = 1.
- NOPS = 4, all mod levels 0x4000, all outputs 0x2000, start -> four writes of 0x4000 to 0x200..0x203 at cycles 6, 12, 18 and 24 after start; done at cycle 25; busy high for exactly 24 cycles.
- Mod levels 0x7FFF, outputs 0x7FFF -> each sum 0x7FFF (clipped); with FMSEQ_SAT_CNT_EN, sat_count = 4. Mod levels 0x8000, outputs 0x7FFF -> each sum 0x8000.
- start held in the same cycle as host_wr_valid -> host write not accepted; the sweep starts; the host write completes in the first IDLE cycle after DONE.
- abort in the WRITE-1 cycle of op 2 -> only 0x200 and 0x201 written, no done, IDLE next cycle. Reset asserted mid-READ -> all outputs 0 immediately.
- Read addresses in op 1 -> rf_r_addr0 = 0x004..0x007 and rf_r_addr1 = 0x100..0x103 on consecutive cycles.
